fp_align_pipe: RTL and testbench

- Parametrised, two-stage pipelined operand-alignment stage for the IEEE-754-style floating-point adder.
- Takes two raw packed operands plus an add/sub mode. Compares exponents and magnitudes, extends hidden bits (denormals included), right-aligns the smaller operand with guard/round/sticky, and two's-complements operands by effective sign.
- Output feeds the mantissa adder directly.
- Valid/ready handshake on both sides, with full backpressure.

---
 rtl/fp_align_pipe.sv | 257 +++++++++++++++++++++++++
 tb/tb_fp_align_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_pipe.sv
// Two-stage operand alignment for the floating-point adder.
// Stage 1 compares the operands and flags specials; stage 2 aligns the smaller
// mantissa (with guard/round/sticky) and two's-complements by effective sign.
module fp_align_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned GRS_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     op_a,
    input  logic [EXP_W+MAN_W:0]     op_b,
    input  logic                     op_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MAN_W+GRS_W+2:0]   man_a_out,
    output logic [MAN_W+GRS_W+2:0]   man_b_out,
    output logic [EXP_W-1:0]         exp_out,
    output logic                     sign_out,
    output logic                     nan_out,
    output logic                     inf_out
);

    localparam int unsigned OP_W  = 1 + EXP_W + MAN_W;
    localparam int unsigned OUT_W = MAN_W + GRS_W + 3;
    localparam int unsigned KEY_W = EXP_W + 1 + MAN_W;
    // Shifting by SAT pushes the hidden bit (the top possible 1) out entirely.
    localparam int unsigned SAT   = MAN_W + GRS_W + 1;
    localparam int unsigned SH_W  = $clog2(SAT + 1);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_adv;

    assign s2_adv   = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_adv;

    // ------------------------------------------------------------------
    // Stage 1: field extraction
    // ------------------------------------------------------------------
    logic               a_sign, b_sign;
    logic [EXP_W-1:0]   a_exp, b_exp;
    logic [MAN_W-1:0]   a_frac, b_frac;
    logic               a_hid, b_hid;
    logic [EXP_W-1:0]   a_eexp, b_eexp;
    logic [KEY_W-1:0]   a_key, b_key;

    assign a_sign = op_a[OP_W-1];
    assign b_sign = op_b[OP_W-1] ^ op_sub;
    assign a_exp  = op_a[MAN_W +: EXP_W];
    assign b_exp  = op_b[MAN_W +: EXP_W];
    assign a_frac = op_a[MAN_W-1:0];
    assign b_frac = op_b[MAN_W-1:0];
    assign a_hid  = |a_exp;
    assign b_hid  = |b_exp;
    assign a_eexp = a_hid ? a_exp : EXP_W'(1);
    assign b_eexp = b_hid ? b_exp : EXP_W'(1);
    // Magnitude key: effective exponent, then hidden bit and fraction.
    assign a_key  = {a_eexp, a_hid, a_frac};
    assign b_key  = {b_eexp, b_hid, b_frac};

    // ------------------------------------------------------------------
    // Stage 1: compare, predict sign, classify specials
    // ------------------------------------------------------------------
    logic               a_small;
    logic               mag_eq;
    logic [EXP_W-1:0]   diff;
    logic [EXP_W-1:0]   exp_big;
    logic               sign_pred;
    logic               a_nan, b_nan, a_inf, b_inf;
    logic               nan_pred, inf_pred;
    logic [OUT_W-1:0]   ext_a, ext_b;

    // Pick the larger operand and derive the result sign and special flags.
    always_comb begin
        a_small   = 1'b0;
        mag_eq    = 1'b0;
        diff      = '0;
        exp_big   = '0;
        sign_pred = 1'b0;
        a_nan     = 1'b0;
        b_nan     = 1'b0;
        a_inf     = 1'b0;
        b_inf     = 1'b0;
        nan_pred  = 1'b0;
        inf_pred  = 1'b0;
        ext_a     = '0;
        ext_b     = '0;

        a_small = (b_key > a_key);
        mag_eq  = (b_key == a_key);

        if (a_small) begin
            diff    = b_eexp - a_eexp;
            exp_big = b_eexp;
        end else begin
            diff    = a_eexp - b_eexp;
            exp_big = a_eexp;
        end

        // Exact cancellation yields +0.
        if (mag_eq && (a_sign != b_sign)) begin
            sign_pred = 1'b0;
        end else begin
            sign_pred = a_small ? b_sign : a_sign;
        end

        a_nan = (&a_exp) &  (|a_frac);
        b_nan = (&b_exp) &  (|b_frac);
        a_inf = (&a_exp) & ~(|a_frac);
        b_inf = (&b_exp) & ~(|b_frac);

        nan_pred = a_nan | b_nan | (a_inf & b_inf & (a_sign != b_sign));
        inf_pred = ~nan_pred & (a_inf | b_inf);
        if (inf_pred) begin
            sign_pred = a_inf ? a_sign : b_sign;
        end

        ext_a = {2'b00, a_hid, a_frac, GRS_W'(0)};
        ext_b = {2'b00, b_hid, b_frac, GRS_W'(0)};
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [OUT_W-1:0]   s1_man_a, s1_man_b;
    logic [EXP_W-1:0]   s1_diff;
    logic [EXP_W-1:0]   s1_exp;
    logic               s1_a_small;
    logic               s1_a_sign, s1_b_sign;
    logic               s1_sign;
    logic               s1_nan, s1_inf;

    // Stage 1 valid: cleared by reset or flush, otherwise follows the input handshake.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // Stage 1 payload: captured on every accepted input.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_man_a   <= '0;
            s1_man_b   <= '0;
            s1_diff    <= '0;
            s1_exp     <= '0;
            s1_a_small <= 1'b0;
            s1_a_sign  <= 1'b0;
            s1_b_sign  <= 1'b0;
            s1_sign    <= 1'b0;
            s1_nan     <= 1'b0;
            s1_inf     <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1_man_a   <= ext_a;
            s1_man_b   <= ext_b;
            s1_diff    <= diff;
            s1_exp     <= exp_big;
            s1_a_small <= a_small;
            s1_a_sign  <= a_sign;
            s1_b_sign  <= b_sign;
            s1_sign    <= sign_pred;
            s1_nan     <= nan_pred;
            s1_inf     <= inf_pred;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: align the smaller mantissa and apply signs
    // ------------------------------------------------------------------
    logic [SH_W-1:0]    shamt;
    logic [OUT_W-1:0]   big_m, small_m;
    logic [OUT_W-1:0]   lost_mask;
    logic [OUT_W-1:0]   aligned_small;
    logic               sticky;
    logic [OUT_W-1:0]   al_a, al_b;
    logic [OUT_W-1:0]   fin_a, fin_b;

    // Saturating right shift with sticky collection, then conditional negate.
    always_comb begin
        shamt         = '0;
        big_m         = '0;
        small_m       = '0;
        lost_mask     = '0;
        aligned_small = '0;
        sticky        = 1'b0;
        al_a          = '0;
        al_b          = '0;
        fin_a         = '0;
        fin_b         = '0;

        big_m   = s1_a_small ? s1_man_b : s1_man_a;
        small_m = s1_a_small ? s1_man_a : s1_man_b;

        if (32'(s1_diff) > SAT) begin
            shamt = SH_W'(SAT);
        end else begin
            shamt = SH_W'(s1_diff);
        end

        lost_mask     = ~({OUT_W{1'b1}} << shamt);
        sticky        = |(small_m & lost_mask);
        aligned_small = (small_m >> shamt) | OUT_W'(sticky);

        al_a = s1_a_small ? aligned_small : big_m;
        al_b = s1_a_small ? big_m : aligned_small;

        // Zero negates to zero modulo 2^OUT_W, so no special case is needed.
        fin_a = (s1_a_sign != s1_sign) ? (~al_a + OUT_W'(1)) : al_a;
        fin_b = (s1_b_sign != s1_sign) ? (~al_b + OUT_W'(1)) : al_b;

        if (s1_nan || s1_inf) begin
            fin_a = '0;
            fin_b = '0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (module outputs)
    // ------------------------------------------------------------------

    // Output valid: cleared by reset or flush, advances when downstream has room.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
        end
    end

    // Output payload: loaded when stage 1 moves forward, held during backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            man_a_out <= '0;
            man_b_out <= '0;
            exp_out   <= '0;
            sign_out  <= 1'b0;
            nan_out   <= 1'b0;
            inf_out   <= 1'b0;
        end else if (s2_adv && s1_valid) begin
            man_a_out <= fin_a;
            man_b_out <= fin_b;
            exp_out   <= s1_exp;
            sign_out  <= s1_sign;
            nan_out   <= s1_nan;
            inf_out   <= s1_inf;
        end
    end

endmodule

// File: tb/tb_fp_align_pipe.sv
// Self-checking bench for fp_align_pipe: directed vectors, backpressure,
// flush/reset, then randomized traffic against an arithmetic reference model.
module tb_fp_align_pipe;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned GRS_W = 3;
    localparam int unsigned OUT_W = MAN_W + GRS_W + 3;
    localparam int          SAT   = MAN_W + GRS_W + 1;

    typedef struct {
        logic [OUT_W-1:0] ma;
        logic [OUT_W-1:0] mb;
        logic [EXP_W-1:0] e;
        logic             s;
        logic             n;
        logic             i;
    } res_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic               op_sub;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   man_a_out;
    logic [OUT_W-1:0]   man_b_out;
    logic [EXP_W-1:0]   exp_out;
    logic               sign_out;
    logic               nan_out;
    logic               inf_out;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;
    res_t expq[$];

    fp_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .GRS_W(GRS_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .man_a_out (man_a_out),
        .man_b_out (man_b_out),
        .exp_out   (exp_out),
        .sign_out  (sign_out),
        .nan_out   (nan_out),
        .inf_out   (inf_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: value-level arithmetic on magnitudes, powers of two and modulus.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        res_t   r;
        int     ea, eb, d, sh;
        longint ma, mb, big, sml, pw, q, va, vb, modv;
        bit     sa, sb, a_big, ana, bna, ainf, binf, nan, inf;
        sa   = a[31];
        sb   = b[31] ^ sub;
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        ma   = longint'(a[22:0]);
        mb   = longint'(b[22:0]);
        ana  = (ea == 255) && (ma != 0);
        bna  = (eb == 255) && (mb != 0);
        ainf = (ea == 255) && (ma == 0);
        binf = (eb == 255) && (mb == 0);
        if (ea == 0) ea = 1; else ma = ma + 8388608;
        if (eb == 0) eb = 1; else mb = mb + 8388608;
        a_big = (ea > eb) || (ea == eb && ma >= mb);
        d     = a_big ? ea - eb : eb - ea;
        r.e   = 8'(a_big ? ea : eb);
        if (ea == eb && ma == mb && sa != sb) r.s = 1'b0;
        else r.s = a_big ? sa : sb;
        big = (a_big ? ma : mb) * 8;
        sml = (a_big ? mb : ma) * 8;
        sh  = (d > SAT) ? SAT : d;
        pw  = longint'(1) << sh;
        q   = sml / pw;
        if (sml % pw != 0) q = q | 1;
        va   = a_big ? big : q;
        vb   = a_big ? q : big;
        modv = longint'(1) << OUT_W;
        if (sa != r.s) va = (modv - va) % modv;
        if (sb != r.s) vb = (modv - vb) % modv;
        nan = ana || bna || (ainf && binf && sa != sb);
        inf = !nan && (ainf || binf);
        if (inf) r.s = ainf ? sa : sb;
        if (nan || inf) begin
            va = 0;
            vb = 0;
        end
        r.ma = OUT_W'(va);
        r.mb = OUT_W'(vb);
        r.n  = nan;
        r.i  = inf;
        return r;
    endfunction

    function automatic logic [31:0] rand_op(input logic [7:0] ref_e);
        logic [31:0] v;
        logic [7:0]  e;
        v = $urandom;
        e = v[30:23];
        case ($urandom_range(0, 7))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2, 3:    e = ref_e + 8'($urandom_range(0, 6)) - 8'd3;
            default: e = v[30:23];
        endcase
        v[30:23] = e;
        if ($urandom_range(0, 5) == 0) v[22:0] = '0;
        return v;
    endfunction

    // One clock cycle of traffic with scoreboard bookkeeping.
    task automatic tick(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic ordy, output logic fired);
        res_t e;
        in_valid  = iv;
        op_a      = a;
        op_b      = b;
        op_sub    = sub;
        out_ready = ordy;
        @(negedge clk);
        fired = in_valid && in_ready && !flush && !rst;
        if (out_valid && out_ready && !rst) begin
            n_out++;
            if (expq.size() == 0) begin
                check("unexpected_out", 64'(1), 64'(0));
            end else begin
                e = expq.pop_front();
                check("man_a", 64'(man_a_out), 64'(e.ma));
                check("man_b", 64'(man_b_out), 64'(e.mb));
                check("exp",   64'(exp_out),   64'(e.e));
                check("nan",   64'(nan_out),   64'(e.n));
                check("inf",   64'(inf_out),   64'(e.i));
                if (!e.n) check("sign", 64'(sign_out), 64'(e.s));
            end
        end
        if (fired) expq.push_back(model(a, b, sub));
        @(posedge clk);
        #1;
    endtask

    // Single isolated operation checked against hand-derived constants and latency.
    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic [OUT_W-1:0] ema,
                            input logic [OUT_W-1:0] emb, input logic [7:0] ee,
                            input logic es, input logic en, input logic ei, input logic chk_s);
        in_valid  = 1'b1;
        op_a      = a;
        op_b      = b;
        op_sub    = sub;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_early_valid"}, 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'(1));
        check({tag, "_man_a"}, 64'(man_a_out), 64'(ema));
        check({tag, "_man_b"}, 64'(man_b_out), 64'(emb));
        check({tag, "_exp"},   64'(exp_out),   64'(ee));
        check({tag, "_nan"},   64'(nan_out),   64'(en));
        check({tag, "_inf"},   64'(inf_out),   64'(ei));
        if (chk_s) check({tag, "_sign"}, 64'(sign_out), 64'(es));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        f;
        logic        pending;
        logic [31:0] x1, x2, x3, ra, rb;
        res_t        m1;
        int          n0;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_man_a",     64'(man_a_out), 64'(0));
        check("rst_man_b",     64'(man_b_out), 64'(0));
        check("rst_exp",       64'(exp_out),   64'(0));
        check("rst_flags",     64'({sign_out, nan_out, inf_out}), 64'(0));
        @(posedge clk);
        #1;

        // Directed vectors
        directed("equal",   32'h3F800000, 32'h3F800000, 1'b0, 29'h04000000, 29'h04000000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b1);
        directed("effsub",  32'h3F800000, 32'hBFC00000, 1'b0, 29'h1C000000, 29'h06000000, 8'd127, 1'b1, 1'b0, 1'b0, 1'b1);
        directed("sticky",  32'h3F800000, 32'h3D800001, 1'b0, 29'h04000000, 29'h00400001, 8'd127, 1'b0, 1'b0, 1'b0, 1'b1);
        directed("a_small", 32'h3D800001, 32'h3F800000, 1'b0, 29'h00400001, 29'h04000000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b1);
        directed("satur",   32'h3F800000, 32'h30800000, 1'b0, 29'h04000000, 29'h00000001, 8'd127, 1'b0, 1'b0, 1'b0, 1'b1);
        directed("denorm",  32'h00000001, 32'h00000000, 1'b0, 29'h00000008, 29'h00000000, 8'd1,   1'b0, 1'b0, 1'b0, 1'b1);
        directed("cancel",  32'h3F800000, 32'hBF800000, 1'b0, 29'h04000000, 29'h1C000000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b1);
        directed("sub_eq",  32'h3F800000, 32'h3F800000, 1'b1, 29'h04000000, 29'h1C000000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b1);
        directed("inf_inf", 32'h7F800000, 32'h7F800000, 1'b1, 29'h0, 29'h0, 8'd255, 1'b0, 1'b1, 1'b0, 1'b0);
        directed("qnan",    32'h7FC00000, 32'h3F800000, 1'b0, 29'h0, 29'h0, 8'd255, 1'b0, 1'b1, 1'b0, 1'b0);
        directed("inf_fin", 32'h7F800000, 32'h3F800000, 1'b0, 29'h0, 29'h0, 8'd255, 1'b0, 1'b0, 1'b1, 1'b1);
        directed("ninf",    32'h3F800000, 32'h7F800000, 1'b1, 29'h0, 29'h0, 8'd255, 1'b1, 1'b0, 1'b1, 1'b1);

        // Backpressure: three back-to-back items with the sink stalled
        x1 = 32'h3F800000;
        x2 = 32'hBFC00000;
        x3 = 32'h40490FDB;
        m1 = model(x1, x2, 1'b0);
        tick(1'b1, x1, x2, 1'b0, 1'b0, f);
        check("bp_acc1", 64'(f), 64'(1));
        tick(1'b1, x2, x3, 1'b1, 1'b0, f);
        check("bp_acc2", 64'(f), 64'(1));
        in_valid  = 1'b1;
        op_a      = x3;
        op_b      = x1;
        op_sub    = 1'b0;
        out_ready = 1'b0;
        #1;
        check("bp_in_ready", 64'(in_ready),  64'(0));
        check("bp_valid",    64'(out_valid), 64'(1));
        check("bp_hold_a",   64'(man_a_out), 64'(m1.ma));
        tick(1'b1, x3, x1, 1'b0, 1'b0, f);
        check("bp_acc3_blocked", 64'(f), 64'(0));
        check("bp_stable_a", 64'(man_a_out), 64'(m1.ma));
        check("bp_stable_b", 64'(man_b_out), 64'(m1.mb));
        check("bp_stable_v", 64'(out_valid), 64'(1));
        n0      = n_out;
        pending = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick(pending, x3, x1, 1'b0, 1'b1, f);
            if (f) pending = 1'b0;
        end
        check("bp_item3_taken", 64'(pending), 64'(0));
        check("bp_delivered",   64'(n_out - n0), 64'(3));
        check("bp_queue_empty", 64'(expq.size()), 64'(0));

        // Flush with two items in flight
        tick(1'b1, x1, x2, 1'b0, 1'b0, f);
        tick(1'b1, x2, x1, 1'b0, 1'b0, f);
        flush = 1'b1;
        tick(1'b0, x3, x3, 1'b0, 1'b0, f);
        flush = 1'b0;
        expq.delete();
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_in_ready",  64'(in_ready),  64'(1));
        n0 = n_out;
        for (int c = 0; c < 4; c++) tick(1'b0, x1, x1, 1'b0, 1'b1, f);
        check("flush_nothing_out", 64'(n_out - n0), 64'(0));

        // Flush dropping a same-cycle input handshake
        tick(1'b1, x1, x2, 1'b0, 1'b0, f);
        flush = 1'b1;
        tick(1'b1, x2, x3, 1'b0, 1'b0, f);
        flush = 1'b0;
        expq.delete();
        n0 = n_out;
        for (int c = 0; c < 4; c++) tick(1'b0, x1, x1, 1'b0, 1'b1, f);
        check("flush_drop_in", 64'(n_out - n0), 64'(0));

        // Reset with two items in flight
        tick(1'b1, x1, x2, 1'b0, 1'b0, f);
        tick(1'b1, x3, x1, 1'b1, 1'b0, f);
        rst = 1'b1;
        tick(1'b1, x2, x2, 1'b0, 1'b1, f);
        rst = 1'b0;
        expq.delete();
        check("rst2_out_valid", 64'(out_valid), 64'(0));
        check("rst2_in_ready",  64'(in_ready),  64'(1));
        check("rst2_man_a",     64'(man_a_out), 64'(0));
        check("rst2_exp",       64'(exp_out),   64'(0));
        n0 = n_out;
        for (int c = 0; c < 4; c++) tick(1'b0, x1, x1, 1'b0, 1'b1, f);
        check("rst2_nothing_out", 64'(n_out - n0), 64'(0));

        // Randomized traffic with random stalls
        for (int c = 0; c < 600; c++) begin
            ra = rand_op(8'($urandom));
            rb = rand_op(ra[30:23]);
            tick(($urandom_range(0, 3) != 0), ra, rb, 1'($urandom),
                 ($urandom_range(0, 3) != 0), f);
        end
        for (int c = 0; c < 20; c++) begin
            if (expq.size() != 0) tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, f);
        end
        check("drain_empty", 64'(expq.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
